link_transmitter: RTL
=====================

LINK_TRANSMITTER -- requirements
Module: link_transmitter

Interface
REQ-001 The block SHALL take parameter DATA_W, default 8, as the flit width in bits.
REQ-002 The block SHALL take parameter LEN_W, default 4, as the header length-field width in bits; LEN_W <= DATA_W.
REQ-003 Reset: one clock; reset is synchronous and active-low.
REQ-004 Port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port i_arst_n  input  1  reset, sampled on i_clk rising edge (synchronous), active-low.
REQ-006 Port i_fifoEmpty  input  1  upstream FIFO empty flag.
REQ-007 Port i_fifoData  input  DATA_W  upstream FIFO head flit, show-ahead (valid whenever i_fifoEmpty=0).
REQ-008 Port o_fifoReadEn  output  1  pop request to upstream FIFO.
REQ-009 Port o_valid  output  1  downstream flit valid.
REQ-010 Port o_data  output  DATA_W  downstream flit.
REQ-011 Port o_last  output  1  marks final flit of a packet, qualified by o_valid.
REQ-012 Port i_ready  input  1  downstream accept; transfer occurs when o_valid && i_ready.
REQ-013 Port o_busy  output  1  high while a packet is partially forwarded (state PAYLOAD).

Function
REQ-014 Packet format SHALL be one header flit followed by N payload flits, N = header[LEN_W-1:0]; N=0 is a single-flit packet.
REQ-015 The FSM SHALL have states IDLE (next flit is a header) and PAYLOAD (remaining count > 0).
REQ-016 Output stage SHALL be one register: loadable when !o_valid || i_ready.
REQ-017 o_fifoReadEn SHALL equal !i_fifoEmpty && (!o_valid || i_ready) && i_arst_n, combinational.
REQ-018 A flit popped at edge N SHALL appear on o_data with o_valid=1 after edge N (latency 1 cycle).
REQ-019 With no pop and a transfer at edge N, o_valid SHALL be 0 after edge N; with no pop and no transfer, o_valid/o_data/o_last SHALL hold.
REQ-020 Simultaneous transfer and pop SHALL replace the output flit in the same edge with no bubble (full throughput 1 flit/cycle).
REQ-021 IDLE + pop: load remaining counter with header length; if length=0, set o_last=1 and stay IDLE; else o_last=0, go PAYLOAD.
REQ-022 PAYLOAD + pop: decrement counter; when counter goes 1->0, set o_last=1 and go IDLE; else o_last=0.
REQ-023 Payload flits SHALL NOT be interpreted as headers regardless of content.
REQ-024 The counter SHALL be LEN_W bits wide and never underflow; max packet is 2^LEN_W flits total including header.
REQ-025 o_data SHALL never change while o_valid && !i_ready (stall stability).
REQ-026 o_busy SHALL be 1 exactly when state = PAYLOAD.

Reset
REQ-027 While i_arst_n=0 at an edge: state IDLE, counter 0, o_valid 0, o_data 0, o_last 0, o_busy 0.
REQ-028 o_fifoReadEn SHALL be 0 during any cycle with i_arst_n=0.
REQ-029 Reset mid-packet SHALL discard the in-flight flit and remaining count; next popped flit is treated as a header.

Configuration
REQ-030 Macro LINK_TRANSMITTER_PARITY_EN SHALL, when defined, add port o_parity output 1 = XOR of o_data, registered alongside o_data, reset 0.
REQ-031 Without LINK_TRANSMITTER_PARITY_EN, o_parity SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-032 Reset, FIFO empty, i_ready=1 -> o_valid=0, o_fifoReadEn=0, o_busy=0 for all cycles.
REQ-033 FIFO holds 8'h02,8'hAA,8'hBB, i_ready=1 -> o_data AA/BB/... sequence 02,AA,BB on consecutive cycles, o_last=1 only on BB, o_busy=1 while in PAYLOAD.
REQ-034 Header 8'h00 then header 8'h01,8'h55 -> o_last=1 on 00, o_last=1 on 55, 55 not treated as header.
REQ-035 Packet 8'h03,11,22,33 with i_ready held 0 for 3 cycles after first o_valid -> o_data stays 03, o_fifoReadEn=0 during stall, no flit lost or duplicated.
REQ-036 Reset asserted after 8'h04,01 forwarded, FIFO then presents 8'h00 -> 00 forwarded with o_last=1, o_busy=0.
REQ-037 With LINK_TRANSMITTER_PARITY_EN, flit 8'h07 -> o_parity=1; flit 8'h03 -> o_parity=0.

Source files
------------

// File: rtl/link_transmitter.sv
// link_transmitter
// Forwards length-framed packets from a show-ahead FIFO onto a valid/ready
// link through a single output register. The first flit of each packet is a
// header whose low LEN_W bits give the number of payload flits that follow.
// Optional feature macro: LINK_TRANSMITTER_PARITY_EN. When it is defined, the
// o_parity output is added. o_parity is the XOR of o_data.
module link_transmitter #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_arst_n,
    input  logic              i_fifoEmpty,
    input  logic [DATA_W-1:0] i_fifoData,
    output logic              o_fifoReadEn,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    input  logic              i_ready,
    output logic              o_busy
`ifdef LINK_TRANSMITTER_PARITY_EN
    ,
    output logic              o_parity
`endif
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic             stage_free;
    logic             pop;
    logic [LEN_W-1:0] hdr_len;

`ifdef LINK_TRANSMITTER_PARITY_EN
    function automatic logic flit_parity(input logic [DATA_W-1:0] flit);
        return ^flit;
    endfunction
`endif

    // Decide whether the output register can take the FIFO head this cycle
    always_comb begin
        stage_free = !o_valid || i_ready;
        pop        = !i_fifoEmpty && stage_free && i_arst_n;
        hdr_len    = i_fifoData[LEN_W-1:0];
    end

    assign o_fifoReadEn = pop;

    // Packet framing FSM and output register; a pop both frames and loads the flit
    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            state     <= IDLE;
            remaining <= {LEN_W{1'b0}};
            o_valid   <= 1'b0;
            o_data    <= {DATA_W{1'b0}};
            o_last    <= 1'b0;
            o_busy    <= 1'b0;
        end else if (pop) begin
            o_valid <= 1'b1;
            o_data  <= i_fifoData;
            case (state)
                IDLE: begin
                    remaining <= hdr_len;
                    if (hdr_len == {LEN_W{1'b0}}) begin
                        o_last <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        o_last <= 1'b0;
                        o_busy <= 1'b1;
                        state  <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    // A count of 0 here cannot happen, but treat it as the
                    // final flit so the counter can never wrap.
                    if (remaining <= LEN_W'(1)) begin
                        remaining <= {LEN_W{1'b0}};
                        o_last    <= 1'b1;
                        o_busy    <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        remaining <= remaining - LEN_W'(1);
                        o_last    <= 1'b0;
                        o_busy    <= 1'b1;
                        state     <= PAYLOAD;
                    end
                end
                default: begin
                    remaining <= {LEN_W{1'b0}};
                    o_last    <= 1'b0;
                    o_busy    <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end else if (i_ready) begin
            // Flit accepted (or none held) with nothing to replace it
            o_valid <= 1'b0;
        end else begin
            o_valid <= o_valid;
        end
    end

`ifdef LINK_TRANSMITTER_PARITY_EN
    // Parity is loaded together with the flit it covers
    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            o_parity <= 1'b0;
        end else if (pop) begin
            o_parity <= flit_parity(i_fifoData);
        end else begin
            o_parity <= o_parity;
        end
    end
`endif

endmodule
